adc_trigger_capture: RTL and testbench

- Consumes the four 12-bit ADC channels that the LVDS receive stage decodes, packed as {d,c,b,a}.
- Arms on request and fills a circular sample buffer.
- Fires on a level-crossing trigger on a selectable channel, keeping a fixed pre-trigger history.
- Streams the frozen capture out over a valid/ready interface to the downstream processing or transfer logic.

---
 rtl/adc_cap_pkg.sv | 18 +
 rtl/adc_cap_ram.sv | 24 ++
 rtl/adc_trigger_capture.sv | 216 +++++++++++++++++++++
 tb/tb_adc_trigger_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared types and default widths for the ADC trigger capture block.
// State encoding, default channel geometry and the packed sample word.
package adc_cap_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_N_CH   = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    RD
  } state_t;

  typedef logic [DEF_N_CH*DEF_DATA_W-1:0] sample_t;

endpackage

// File: rtl/adc_cap_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Written to infer block RAM; contents are not reset.
module adc_cap_ram #(
  parameter int W     = 48,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// Level-crossing triggered capture of packed ADC channels with stream readout.
// Define ADC_CAP_TIMESTAMP_EN to add the trig_ts sample-count timestamp.
module adc_trigger_capture
  import adc_cap_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int N_CH     = DEF_N_CH,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   in_samples,
  input  logic                     in_valid,
  input  logic                     arm,
  input  logic [$clog2(N_CH)-1:0]  trig_ch,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic                     trig_falling,
  output logic                     busy,
  output logic                     triggered,
`ifdef ADC_CAP_TIMESTAMP_EN
  output logic [31:0]              trig_ts,
`endif
  output logic [N_CH*DATA_W-1:0]   m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  localparam int SW     = N_CH*DATA_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(N_CH);
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [AW:0] PRE_LAST  = (AW+1)'(PRE_TRIG - 1);
  localparam logic [AW:0] POST_LAST = (AW+1)'(POST_N - 1);
  localparam logic [AW:0] RD_LAST   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] RD_N      = (AW+1)'(DEPTH);

  state_t state, state_nx;

  logic [AW:0]     cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   trig_addr;
  logic [CW-1:0]   cfg_ch;
  logic [DATA_W-1:0] cfg_level;
  logic            cfg_falling;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] cur;

  logic wr_en, hit, trig_fire;
  logic pre_done, post_done, rd_done;

  logic [AW-1:0] rd_ptr;
  logic [AW:0]   rd_cnt;
  logic          issue, pop, push;
  logic          inflight, inflight_last;
  logic [SW-1:0] rd_q;
  logic [1:0]    occ;
  logic [2:0]    need;
  logic [SW-1:0] q0, q1;
  logic          l0, l1;

  always_comb begin
    cur = '0;
    for (int k = 0; k < N_CH; k++)
      if (cfg_ch == CW'(k)) cur = in_samples[k*DATA_W +: DATA_W];
  end

  assign wr_en = in_valid &&
    (state == PRE || state == ARMED || state == POST);

  assign hit = cfg_falling
    ? (prev >= cfg_level && cur <  cfg_level)
    : (prev <  cfg_level && cur >= cfg_level);

  assign trig_fire = (state == ARMED) && in_valid && hit;
  assign pre_done  = (state == PRE)  && in_valid && cnt == PRE_LAST;
  assign post_done = (state == POST) && in_valid && cnt == POST_LAST;
  assign rd_done   = pop && m_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (arm) state_nx = (PRE_TRIG == 0) ? ARMED : PRE;
      PRE:   if (pre_done) state_nx = ARMED;
      ARMED: if (trig_fire) state_nx = (POST_N == 0) ? RD : POST;
      POST:  if (post_done) state_nx = RD;
      RD:    if (rd_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      wr_ptr      <= '0;
      trig_addr   <= '0;
      cfg_ch      <= '0;
      cfg_level   <= '0;
      cfg_falling <= 1'b0;
      prev        <= '0;
      triggered   <= 1'b0;
    end else begin
      if (state == IDLE && arm) begin
        cfg_ch      <= trig_ch;
        cfg_level   <= trig_level;
        cfg_falling <= trig_falling;
        prev        <= trig_falling ? '1 : '0;
        cnt         <= '0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        prev   <= cur;
        cnt    <= cnt + 1'b1;
      end
      if (pre_done) cnt <= '0;
      if (trig_fire) begin
        trig_addr <= wr_ptr;
        triggered <= 1'b1;
        cnt       <= '0;
      end
      if (rd_done) triggered <= 1'b0;
    end
  end

  adc_cap_ram #(.W(SW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (in_samples),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (rd_q)
  );

  // Reads are issued only while the skid pair can absorb them.
  assign m_valid = (occ != 2'd0);
  assign m_data  = q0;
  assign m_last  = l0 && m_valid;
  assign pop     = m_valid && m_ready;
  assign push    = inflight;
  assign need    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign issue   = (state == RD) && (rd_cnt != RD_N) && (need < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      occ           <= '0;
      q0            <= '0;
      q1            <= '0;
      l0            <= 1'b0;
      l1            <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= (rd_cnt == RD_LAST);
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (trig_fire) begin
        rd_ptr <= wr_ptr - AW'(PRE_TRIG);
        rd_cnt <= '0;
      end
      if (push && pop) begin
        if (occ == 2'd2) begin
          q0 <= q1;
          l0 <= l1;
          q1 <= rd_q;
          l1 <= inflight_last;
        end else begin
          q0 <= rd_q;
          l0 <= inflight_last;
        end
      end else if (push) begin
        if (occ == 2'd0) begin
          q0 <= rd_q;
          l0 <= inflight_last;
        end else begin
          q1 <= rd_q;
          l1 <= inflight_last;
        end
        occ <= occ + 2'd1;
      end else if (pop) begin
        q0  <= q1;
        l0  <= l1;
        occ <= occ - 2'd1;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef ADC_CAP_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt  <= '0;
      trig_ts <= '0;
    end else begin
      if (in_valid) ts_cnt <= ts_cnt + 32'd1;
      if (trig_fire) trig_ts <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed bench for adc_trigger_capture with DEPTH=16, PRE_TRIG=4.
// Immediate assertions count failures; one summary line at the end.
module tb_adc_trigger_capture;
  import adc_cap_pkg::*;

  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  logic        clk = 1'b0;
  logic        rst;
  sample_t     in_samples;
  logic        in_valid;
  logic        arm;
  logic [1:0]  trig_ch;
  logic [11:0] trig_level;
  logic        trig_falling;
  logic        busy;
  logic        triggered;
  sample_t     m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
`ifdef ADC_CAP_TIMESTAMP_EN
  logic [31:0] trig_ts;
`endif

  int n_run  = 0;
  int n_fail = 0;
  sample_t exp_q [DEPTH];

  always #5 clk = ~clk;

  adc_trigger_capture #(
    .DATA_W(12), .N_CH(4), .DEPTH(DEPTH), .PRE_TRIG(PRE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_samples   (in_samples),
    .in_valid     (in_valid),
    .arm          (arm),
    .trig_ch      (trig_ch),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .busy         (busy),
    .triggered    (triggered),
`ifdef ADC_CAP_TIMESTAMP_EN
    .trig_ts      (trig_ts),
`endif
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] expv);
    n_run++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input sample_t s, input logic v);
    in_samples = s;
    in_valid   = v;
    tick();
  endtask

  function automatic sample_t pk(input int ch, input int val);
    sample_t w;
    w = '0;
    w[ch*12 +: 12] = 12'(val);
    return w;
  endfunction

  function automatic sample_t w4(input int j);
    int b;
    if (j < 30)       b = 200;
    else if (j == 30) b = 50;
    else              b = 150 + (j - 31);
    return pk(1, b) | pk(0, (j % 2) * 200);
  endfunction

  task automatic cfg(input int ch, input int lvl, input logic fall);
    trig_ch      = 2'(ch);
    trig_level   = 12'(lvl);
    trig_falling = fall;
  endtask

  task automatic read_all(input string tag, input bit rnd);
    int      beats;
    bit      done;
    bit      stalled;
    sample_t held;
    beats   = 0;
    done    = 1'b0;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check({tag, "_hold"}, {m_valid, m_data}, {1'b1, held});
        stalled = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (beats < DEPTH) begin
          check({tag, "_data"}, m_data, exp_q[beats]);
          check({tag, "_last"}, m_last, beats == DEPTH - 1);
        end else begin
          check({tag, "_extra_beat"}, beats, DEPTH - 1);
        end
        check({tag, "_trig_rd"}, triggered, 1'b1);
        done  = m_last;
        beats++;
      end else if (m_valid) begin
        held    = m_data;
        stalled = 1'b1;
      end
      tick();
    end
    m_ready = 1'b0;
    check({tag, "_beats"}, beats, DEPTH);
    check({tag, "_idle"}, {busy, triggered, m_valid}, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    rst        = 1'b1;
    in_samples = '0;
    in_valid   = 1'b0;
    arm        = 1'b0;
    m_ready    = 1'b0;
    cfg(0, 0, 1'b0);
    tick(); tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_trig", triggered, 1'b0);
    check("rst_mvalid", m_valid, 1'b0);
    check("rst_mlast", m_last, 1'b0);
    check("rst_mdata", m_data, 48'h0);
`ifdef ADC_CAP_TIMESTAMP_EN
    check("rst_ts", trig_ts, 32'd0);
`endif
    rst = 1'b0;

    // rising ramp on a, trigger at 100
    cfg(0, 100, 1'b0);
    for (int k = 0; k < 112; k++) begin
      arm = (k == 0);
      feed(pk(0, k), 1'b1);
    end
    arm = 1'b0;
    feed(pk(0, 112), 1'b1);
    feed(pk(0, 113), 1'b1);
    check("ramp_first_valid", m_valid, 1'b1);
    check("ramp_first_data", m_data, pk(0, 96));
    check("ramp_busy", busy, 1'b1);
    check("ramp_trig", triggered, 1'b1);
`ifdef ADC_CAP_TIMESTAMP_EN
    check("ramp_ts", trig_ts, 32'd100);
`endif
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q[i] = pk(0, 96 + i);
    read_all("ramp", 1'b0);

    // falling ramp on c, trigger at 1999
    cfg(2, 2000, 1'b1);
    for (int k = 0; k < 2108; k++) begin
      arm = (k == 0);
      feed(pk(2, 4095 - k), 1'b1);
    end
    arm = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q[i] = pk(2, 2003 - i);
    read_all("fall", 1'b0);

    // gapped input, random backpressure
    cfg(0, 100, 1'b0);
    for (int k = 0; k < 112; k++) begin
      arm = (k == 0);
      feed(pk(0, k), 1'b1);
      arm = 1'b0;
      feed(pk(0, 12'h800), 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) exp_q[i] = pk(0, 96 + i);
    read_all("gap", 1'b1);

    // level already high, dip, rise; arm during POST ignored
    cfg(1, 100, 1'b0);
    for (int j = 0; j < 43; j++) begin
      arm = (j == 0) || (j == 35);
      if (j == 30) begin
        check("hi_no_trig", triggered, 1'b0);
        check("hi_busy", busy, 1'b1);
      end
      feed(w4(j), 1'b1);
    end
    arm = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q[i] = w4(27 + i);
    read_all("dip", 1'b0);

    // reset during readout at beat 7
    cfg(0, 100, 1'b0);
    for (int k = 0; k < 112; k++) begin
      arm = (k == 0);
      feed(pk(0, k), 1'b1);
    end
    arm = 1'b0;
    in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && got < 7; c++) begin
      m_ready = 1'b1;
      if (m_valid) begin
        check("mid_data", m_data, pk(0, 96 + got));
        got++;
      end
      tick();
    end
    check("mid_got", got, 7);
    rst     = 1'b1;
    m_ready = 1'b0;
    tick();
    check("mid_rst_mvalid", m_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_trig", triggered, 1'b0);
    check("mid_rst_last", m_last, 1'b0);
`ifdef ADC_CAP_TIMESTAMP_EN
    check("mid_rst_ts", trig_ts, 32'd0);
`endif
    rst = 1'b0;
    cfg(0, 400, 1'b0);
    for (int k = 0; k < 112; k++) begin
      arm = (k == 0);
      feed(pk(0, 300 + k), 1'b1);
    end
    arm = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q[i] = pk(0, 396 + i);
    read_all("rearm", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
